// File: rtl/pixel_input.sv
// pixel_input: camera byte capture, word packing, word FIFO and SRAM write path.
// Optional macro PIXEL_INPUT_TESTPAT_EN replaces cam_data with a per-frame byte counter.
module pixel_input #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] MAX_WORDS  = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        capture_en,
  input  logic        cam_pclk,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic        sram_start,
  output logic        sram_rw,
  output logic [15:0] sram_addr,
  output logic [15:0] sram_wdata,
  input  logic        sram_ready,
  output logic [15:0] stop_addr,
  output logic        frame_done,
  output logic        overflow
);
  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [2:0] {C_IDLE, C_ARMED, C_FRAME, C_FLUSH, C_DONE} cap_state_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_WAIT} wr_state_t;

  function automatic logic addr_at_limit(input logic [15:0] a);
    return a == MAX_WORDS;
  endfunction

  function automatic logic [15:0] addr_inc(input logic [15:0] a);
    return (a == MAX_WORDS) ? a : a + 16'd1;
  endfunction

  cap_state_t  cap_state, cap_next;
  wr_state_t   wr_state, wr_next;
  logic        in_frame, frame_start, done_now;
  logic        pop, push_ok, push_drop, fifo_empty, fifo_full;
  logic [15:0] wr_addr;

  // Stage p0/p1: two-flop synchronizers; p2 holds the previous p1 for edge detection
  logic pclk_p0, pclk_p1, pclk_p2;
  logic vsync_p0, vsync_p1, vsync_p2;
  logic href_p0, href_p1, href_p2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {pclk_p0, pclk_p1, pclk_p2}    <= '0;
      {vsync_p0, vsync_p1, vsync_p2} <= '0;
      {href_p0, href_p1, href_p2}    <= '0;
    end else begin
      {pclk_p0, pclk_p1, pclk_p2}    <= {cam_pclk, pclk_p0, pclk_p1};
      {vsync_p0, vsync_p1, vsync_p2} <= {cam_vsync, vsync_p0, vsync_p1};
      {href_p0, href_p1, href_p2}    <= {cam_href, href_p0, href_p1};
    end
  end

  logic       vld_p1, vsync_rise_p1, vsync_fall_p1, href_fall_p1;
  logic [7:0] byte_p1;

  assign vld_p1        = in_frame & pclk_p1 & ~pclk_p2 & href_p1 & ~vsync_p1;
  assign vsync_rise_p1 = vsync_p1 & ~vsync_p2;
  assign vsync_fall_p1 = ~vsync_p1 & vsync_p2;
  assign href_fall_p1  = ~href_p1 & href_p2;

`ifdef PIXEL_INPUT_TESTPAT_EN
  logic [7:0] tp_cnt;
  logic       unused_cam_data;
  assign unused_cam_data = ^cam_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            tp_cnt <= '0;
    else if (frame_start) tp_cnt <= '0;
    else if (vld_p1)      tp_cnt <= tp_cnt + 8'd1;
  end
  assign byte_p1 = tp_cnt;
`else
  logic [7:0] data_p0, data_p1;

  always_ff @(posedge clk) begin
    data_p0 <= cam_data;
    data_p1 <= data_p0;
  end
  assign byte_p1 = data_p1;
`endif

  // Stage p2: byte pairing; a half word never survives a line or frame boundary
  logic        pend_vld_p2, push_p2;
  logic [7:0]  pend_hi_p2;
  logic [15:0] push_word_p2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_vld_p2 <= 1'b0;
      push_p2     <= 1'b0;
    end else begin
      push_p2 <= 1'b0;
      if (!in_frame || href_fall_p1) begin
        pend_vld_p2 <= 1'b0;
      end else if (vld_p1) begin
        pend_vld_p2 <= ~pend_vld_p2;
        push_p2     <= pend_vld_p2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p1) begin
      if (pend_vld_p2) push_word_p2 <= {pend_hi_p2, byte_p1};
      else             pend_hi_p2   <= byte_p1;
    end
  end

  // Stage p3: word FIFO; a full FIFO still accepts a push when the head leaves the same cycle
  logic [15:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_ok    = push_p2 & (~fifo_full | pop);
  assign push_drop  = push_p2 & fifo_full & ~pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr[AW-1:0]] <= push_word_p2;
  end

  // Capture FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cap_state <= C_IDLE;
    else       cap_state <= cap_next;
  end

  always_comb begin
    cap_next = cap_state;
    unique case (cap_state)
      C_IDLE:  if (capture_en && vsync_p1) cap_next = C_ARMED;
      C_ARMED: if (vsync_fall_p1) cap_next = C_FRAME;
      C_FRAME: if (vsync_rise_p1) cap_next = C_FLUSH;
      C_FLUSH: if (fifo_empty && !push_p2 && wr_state == W_IDLE) cap_next = C_DONE;
      C_DONE:  cap_next = (capture_en && vsync_p1) ? C_ARMED : C_IDLE;
      default: cap_next = C_IDLE;
    endcase
  end

  always_comb begin
    in_frame    = 1'b0;
    frame_start = 1'b0;
    done_now    = 1'b0;
    unique case (cap_state)
      C_ARMED: frame_start = vsync_fall_p1;
      C_FRAME: in_frame    = 1'b1;
      C_DONE:  done_now    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stop_addr  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= done_now;
      if (done_now) stop_addr <= wr_addr;
    end
  end

  // Write FSM: the head is popped in W_IDLE so address and data are valid when start rises
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wr_state <= W_IDLE;
    else       wr_state <= wr_next;
  end

  always_comb begin
    wr_next = wr_state;
    unique case (wr_state)
      W_IDLE:  if (!fifo_empty && !addr_at_limit(wr_addr)) wr_next = W_REQ;
      W_REQ:   wr_next = W_WAIT;
      W_WAIT:  if (sram_ready) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  always_comb begin
    sram_start = (wr_state == W_REQ);
    pop        = (wr_state == W_IDLE) && !fifo_empty;
  end

  assign sram_rw = 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_addr    <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      overflow   <= 1'b0;
    end else begin
      if (frame_start) begin
        wr_addr  <= '0;
        overflow <= 1'b0;
      end else begin
        if (wr_state == W_WAIT && sram_ready) wr_addr <= addr_inc(wr_addr);
        if (push_drop || (pop && addr_at_limit(wr_addr))) overflow <= 1'b1;
      end
      if (pop && !addr_at_limit(wr_addr)) begin
        sram_addr  <= wr_addr;
        sram_wdata <= fifo_mem[rd_ptr[AW-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_pixel_input.sv
// tb_pixel_input: drives camera frames into a default instance and a MAX_WORDS=3 instance,
// answers SRAM requests and compares writes, stop_addr and overflow against a frame model.
module tb_pixel_input;
  logic        clk = 1'b0, reset = 1'b1, capture_en = 1'b0;
  logic        cam_pclk = 1'b0, cam_vsync = 1'b1, cam_href = 1'b0;
  logic [7:0]  cam_data = 8'h00;
  logic        ready_a = 1'b0, ready_b = 1'b0;
  logic        start_a, rw_a, fdone_a, ovf_a, start_b, rw_b, fdone_b, ovf_b;
  logic [15:0] addr_a, wdata_a, stop_a, addr_b, wdata_b, stop_b;

  always #5 clk = ~clk;

  pixel_input #(.FIFO_DEPTH(4), .MAX_WORDS(16'hFFFF)) dut (
    .clk(clk), .reset(reset), .capture_en(capture_en), .cam_pclk(cam_pclk),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .sram_start(start_a), .sram_rw(rw_a), .sram_addr(addr_a), .sram_wdata(wdata_a),
    .sram_ready(ready_a), .stop_addr(stop_a), .frame_done(fdone_a), .overflow(ovf_a));

  pixel_input #(.FIFO_DEPTH(4), .MAX_WORDS(16'd3)) dut_sat (
    .clk(clk), .reset(reset), .capture_en(capture_en), .cam_pclk(cam_pclk),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .sram_start(start_b), .sram_rw(rw_b), .sram_addr(addr_b), .sram_wdata(wdata_b),
    .sram_ready(ready_b), .stop_addr(stop_b), .frame_done(fdone_b), .overflow(ovf_b));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [7:0]  byte_q[$];
  int          len_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] wa_q[$], wd_q[$], sa_q[$], sd_q[$];
  int          lat = 2;
  int          fd_a = 0, fd_b = 0;
  bit          drop_en_mid = 1'b0;

  // SRAM mux model: records each start, answers with ready 'lat' cycles later
  int          cnt_a = 0, cnt_b = 0;
  logic [15:0] hold_addr_a, hold_data_a, hold_addr_b, hold_data_b;

  always @(negedge clk) begin
    if (reset) begin
      cnt_a = 0;
      ready_a = 1'b0;
    end else begin
      ready_a = 1'b0;
      if (cnt_a > 0) begin
        chk("a_addr_stable", addr_a, hold_addr_a);
        chk("a_data_stable", wdata_a, hold_data_a);
        chk("a_one_outstanding", start_a, 0);
        cnt_a--;
        if (cnt_a == 0) ready_a = 1'b1;
      end else if (start_a === 1'b1) begin
        chk("a_rw", rw_a, 1);
        wa_q.push_back(addr_a);
        wd_q.push_back(wdata_a);
        hold_addr_a = addr_a;
        hold_data_a = wdata_a;
        cnt_a = lat;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      cnt_b = 0;
      ready_b = 1'b0;
    end else begin
      ready_b = 1'b0;
      if (cnt_b > 0) begin
        chk("b_addr_stable", addr_b, hold_addr_b);
        chk("b_data_stable", wdata_b, hold_data_b);
        chk("b_one_outstanding", start_b, 0);
        cnt_b--;
        if (cnt_b == 0) ready_b = 1'b1;
      end else if (start_b === 1'b1) begin
        chk("b_rw", rw_b, 1);
        sa_q.push_back(addr_b);
        sd_q.push_back(wdata_b);
        hold_addr_b = addr_b;
        hold_data_b = wdata_b;
        cnt_b = lat;
      end
    end
  end

  always @(negedge clk) begin
    if (fdone_a === 1'b1) fd_a++;
    if (fdone_b === 1'b1) fd_b++;
  end

  task automatic clear_writes();
    wa_q.delete(); wd_q.delete(); sa_q.delete(); sd_q.delete();
  endtask

  // Drives one frame from byte_q/len_q and builds the expected word list alongside
  task automatic send_frame();
    int         idx;
    logic [7:0] v, hi, tp;
    bit         have;
    idx = 0;
    tp = 8'd0;
    hi = 8'd0;
    exp_q.delete();
    @(negedge clk); #2;
    cam_vsync = 1'b1; #100;
    cam_vsync = 1'b0; #80;
    if (drop_en_mid) capture_en = 1'b0;
    foreach (len_q[l]) begin
      cam_href = 1'b1;
      have = 1'b0;
      for (int k = 0; k < len_q[l]; k++) begin
        cam_data = byte_q[idx];
        idx++;
`ifdef PIXEL_INPUT_TESTPAT_EN
        v = tp;
        tp = tp + 8'd1;
`else
        v = cam_data;
`endif
        if (have) begin
          exp_q.push_back({hi, v});
          have = 1'b0;
        end else begin
          hi = v;
          have = 1'b1;
        end
        #20 cam_pclk = 1'b1;
        #20 cam_pclk = 1'b0;
      end
      #40 cam_href = 1'b0;
      #80;
    end
    cam_vsync = 1'b1;
  endtask

  task automatic wait_done(input string name);
    int a0, b0, n;
    a0 = fd_a;
    b0 = fd_b;
    n = 0;
    while ((fd_a == a0 || fd_b == b0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done_in_time"}, n < 3000, 1);
    repeat (20) @(negedge clk);
    chk({name, "_frame_done_a"}, fd_a - a0, 1);
    chk({name, "_frame_done_b"}, fd_b - b0, 1);
  endtask

  task automatic check_frame(input string name);
    int ns;
    chk({name, "_nwr_a"}, wa_q.size(), exp_q.size());
    for (int i = 0; i < wa_q.size() && i < exp_q.size(); i++) begin
      chk({name, "_addr_a"}, wa_q[i], i);
      chk({name, "_data_a"}, wd_q[i], exp_q[i]);
    end
    chk({name, "_stop_a"}, stop_a, exp_q.size());
    chk({name, "_ovf_a"}, ovf_a, 0);
    ns = (exp_q.size() > 3) ? 3 : exp_q.size();
    chk({name, "_nwr_b"}, sa_q.size(), ns);
    for (int i = 0; i < sa_q.size() && i < ns; i++) begin
      chk({name, "_addr_b"}, sa_q[i], i);
      chk({name, "_data_b"}, sd_q[i], exp_q[i]);
    end
    chk({name, "_stop_b"}, stop_b, ns);
    chk({name, "_ovf_b"}, ovf_b, exp_q.size() > 3);
    clear_writes();
  endtask

  typedef struct packed {
    logic [95:0] bytes;
    int          nbytes;
    int          lat;
    int          stop_a;
    int          ovf_a;
    int          stop_b;
    int          ovf_b;
  } vec_t;

  vec_t tab [8];

  initial begin
    int j, a0, nl, nb;
    tab[0] = '{96'h1122334455667788_00000000, 8, 2, 4, 0, 3, 1};
    tab[1] = '{96'hAABBCC00_0000000000000000, 3, 2, 1, 0, 1, 0};
    tab[2] = '{96'h0102030405060708090A0000, 10, 2, 5, 0, 3, 1};
    tab[3] = '{96'h0, 0, 1, 0, 0, 0, 0};
    tab[4] = '{96'h5AA50000_0000000000000000, 2, 1, 1, 0, 1, 0};
    tab[5] = '{96'hC3D4E5F60718000000000000, 6, 4, 3, 0, 3, 0};
    tab[6] = '{96'h77000000_0000000000000000, 1, 3, 0, 0, 0, 0};
    tab[7] = '{96'h9192939495969700_00000000, 7, 2, 3, 0, 3, 0};

    #12;
    chk("rst_sram_start", start_a, 0);
    chk("rst_sram_rw", rw_a, 1);
    chk("rst_sram_addr", addr_a, 0);
    chk("rst_sram_wdata", wdata_a, 0);
    chk("rst_stop_addr", stop_a, 0);
    chk("rst_frame_done", fdone_a, 0);
    chk("rst_overflow", ovf_a, 0);
    @(negedge clk);
    reset = 1'b0;
    capture_en = 1'b1;

    for (int t = 0; t < 8; t++) begin
      byte_q.delete();
      len_q.delete();
      for (int i = 0; i < tab[t].nbytes; i++) byte_q.push_back(tab[t].bytes[95-8*i -: 8]);
      len_q.push_back(tab[t].nbytes);
      lat = tab[t].lat;
      send_frame();
      wait_done("tab");
      chk("tab_stop_a", stop_a, tab[t].stop_a);
      chk("tab_ovf_a", ovf_a, tab[t].ovf_a);
      chk("tab_stop_b", stop_b, tab[t].stop_b);
      chk("tab_ovf_b", ovf_b, tab[t].ovf_b);
      check_frame("tab");
    end

    // Backpressure: 12 bytes at full pclk rate against a 40-cycle SRAM
    byte_q.delete();
    len_q.delete();
    for (int i = 0; i < 12; i++) byte_q.push_back(8'h20 + 8'(i));
    len_q.push_back(12);
    lat = 40;
    send_frame();
    wait_done("bp");
    chk("bp_overflow", ovf_a, 1);
    chk("bp_stop_is_written", stop_a, wa_q.size());
    chk("bp_some_written", wa_q.size() > 0, 1);
    chk("bp_not_all_written", wa_q.size() < exp_q.size(), 1);
    j = 0;
    for (int i = 0; i < wa_q.size(); i++) begin
      while (j < exp_q.size() && exp_q[j] != wd_q[i]) j++;
      if (i == 0) chk("bp_first_word", j, 0);
      chk("bp_in_order", j < exp_q.size(), 1);
      chk("bp_addr", wa_q[i], i);
      j++;
    end
    clear_writes();

    // Reset while the first access of a frame is in flight
    byte_q.delete();
    len_q.delete();
    for (int i = 0; i < 8; i++) byte_q.push_back(8'h40 + 8'(i));
    len_q.push_back(8);
    lat = 40;
    fork
      send_frame();
      begin
        int n;
        n = 0;
        while (start_a !== 1'b1 && n < 2000) begin
          @(negedge clk);
          n++;
        end
        chk("rst_mid_start_seen", n < 2000, 1);
        chk("rst_mid_stop_before", stop_a != 16'd0, 1);
        #1 reset = 1'b1;
        #1;
        chk("rst_mid_start_drop", start_a, 0);
        chk("rst_mid_stop_a", stop_a, 0);
        chk("rst_mid_stop_b", stop_b, 0);
        chk("rst_mid_overflow", ovf_a, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
      end
    join
    clear_writes();
    byte_q.delete();
    len_q.delete();
    for (int i = 0; i < 4; i++) byte_q.push_back(8'h60 + 8'(i));
    len_q.push_back(4);
    lat = 2;
    send_frame();
    wait_done("after_rst");
    check_frame("after_rst");

    // Dropping capture_en mid-frame finishes that frame, then further frames are ignored
    drop_en_mid = 1'b1;
    send_frame();
    drop_en_mid = 1'b0;
    wait_done("en_drop");
    check_frame("en_drop");
    a0 = fd_a;
    send_frame();
    repeat (300) @(negedge clk);
    chk("disabled_frame_done", fd_a - a0, 0);
    chk("disabled_writes", wa_q.size(), 0);
    capture_en = 1'b1;
    clear_writes();

    // Randomized multi-line frames
    for (int f = 0; f < 6; f++) begin
      byte_q.delete();
      len_q.delete();
      nl = $urandom_range(1, 3);
      for (int l = 0; l < nl; l++) begin
        nb = $urandom_range(0, 9);
        len_q.push_back(nb);
        for (int i = 0; i < nb; i++) byte_q.push_back(8'($urandom));
      end
      lat = $urandom_range(1, 4);
      send_frame();
      wait_done("rnd");
      check_frame("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
